// File: rtl/pid_duty_compensator.sv
`default_nettype none
// ============================================================================
// Module      : pid_duty_compensator
// Description : Discrete velocity-form PID compensator feeding the deadtime
//               DPWM. One ADC sample is processed per request:
//                   u[n] = u[n-1] + A*e[n] + B*e[n-1] + C*e[n-2]
//               with e = vref - adc_code. Three multiplies share a single
//               multiplier sequenced by a small FSM. The result is clamped
//               (which also provides anti-windup) and truncated to the
//               DPWM duty word d_n.
//
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               enable       - loop enable; low holds the loop cleared
//               sample_valid - 1-cycle strobe, adc_code carries a new sample
//               adc_code     - measured output code (unsigned, ADC_W)
//               vref         - target code (unsigned, ADC_W)
//               coef_a/b/c   - signed Q(COEF_W-FRAC).FRAC coefficients
//               d_n          - registered duty word to the DPWM
//               d_valid      - 1-cycle strobe while the new d_n is presented
//               busy         - high while a computation is in flight
//
// Options     : `define PID_SOFT_START_EN adds a soft-start ramp register
//               that limits the upper clamp, rising by one count per
//               update until it reaches DUTY_MAX.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pid_duty_compensator #(
    parameter int ADC_W    = 8,
    parameter int DUTY_W   = 6,
    parameter int COEF_W   = 10,
    parameter int FRAC     = 6,
    parameter int DUTY_MIN = 1,
    parameter int DUTY_MAX = 52
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  adc_code,
    input  logic [ADC_W-1:0]  vref,
    input  logic [COEF_W-1:0] coef_a,
    input  logic [COEF_W-1:0] coef_b,
    input  logic [COEF_W-1:0] coef_c,
    output logic [DUTY_W-1:0] d_n,
    output logic              d_valid,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int c_err_w  = ADC_W + 1;            // signed error
    localparam int c_prod_w = COEF_W + ADC_W + 1;   // signed product
    localparam int c_acc_w  = COEF_W + ADC_W + 4;   // signed accumulator
    localparam int c_u_w    = DUTY_W + FRAC;        // unsigned stored u

    localparam logic [c_u_w-1:0]  c_u_min    = c_u_w'(DUTY_MIN << FRAC);
    localparam logic [DUTY_W-1:0] c_duty_min = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] c_duty_max = DUTY_W'(DUTY_MAX);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MAC0 = 3'd2,
        ST_MAC1 = 3'd3,
        ST_MAC2 = 3'd4,
        ST_SAT  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic        [ADC_W-1:0]   r_adc;
    logic        [ADC_W-1:0]   r_vref;
    logic signed [COEF_W-1:0]  r_coef_a;
    logic signed [COEF_W-1:0]  r_coef_b;
    logic signed [COEF_W-1:0]  r_coef_c;
    logic signed [c_err_w-1:0] r_e;
    logic signed [c_err_w-1:0] r_e1;
    logic signed [c_err_w-1:0] r_e2;
    logic signed [c_acc_w-1:0] r_acc;
    logic        [c_u_w-1:0]   r_u;
    logic        [DUTY_W-1:0]  r_d_n;
`ifdef PID_SOFT_START_EN
    logic        [DUTY_W-1:0]  r_ramp;
`endif

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic signed [c_err_w-1:0]  w_err;
    logic signed [COEF_W-1:0]   w_mul_coef;
    logic signed [c_err_w-1:0]  w_mul_err;
    logic signed [c_prod_w-1:0] w_coef_ext;
    logic signed [c_prod_w-1:0] w_err_ext;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_prod_ext;
    logic signed [c_acc_w-1:0]  w_u_ext;
    logic signed [c_acc_w-1:0]  w_acc_base;
    logic signed [c_acc_w-1:0]  w_sum;
    logic        [DUTY_W-1:0]   w_hi_duty;
    logic        [c_u_w-1:0]    w_hi_u;
    logic signed [c_acc_w-1:0]  w_hi_acc;
    logic signed [c_acc_w-1:0]  w_lo_acc;
    logic        [c_u_w-1:0]    w_u_sat;

    // Error is formed from zero-extended unsigned codes, so it always fits
    // in ADC_W+1 signed bits.
    assign w_err = $signed({1'b0, r_vref}) - $signed({1'b0, r_adc});

    // Operand select for the single shared multiplier.
    always_comb begin
        w_mul_coef = r_coef_a;
        w_mul_err  = r_e;
        case (r_state)
            ST_MAC1: begin
                w_mul_coef = r_coef_b;
                w_mul_err  = r_e1;
            end
            ST_MAC2: begin
                w_mul_coef = r_coef_c;
                w_mul_err  = r_e2;
            end
            default: ;
        endcase
    end

    assign w_coef_ext = $signed({{(c_prod_w-COEF_W){w_mul_coef[COEF_W-1]}}, w_mul_coef});
    assign w_err_ext  = $signed({{(c_prod_w-c_err_w){w_mul_err[c_err_w-1]}}, w_mul_err});
    assign w_prod     = w_coef_ext * w_err_ext;
    assign w_prod_ext = $signed({{(c_acc_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod});

    // MAC0 starts the sum from the previous output; later MACs accumulate.
    assign w_u_ext    = $signed({{(c_acc_w-c_u_w){1'b0}}, r_u});
    assign w_acc_base = (r_state == ST_MAC0) ? w_u_ext : r_acc;
    assign w_sum      = w_acc_base + w_prod_ext;

`ifdef PID_SOFT_START_EN
    assign w_hi_duty = r_ramp;
`else
    assign w_hi_duty = c_duty_max;
`endif

    assign w_hi_u   = {w_hi_duty, {FRAC{1'b0}}};
    assign w_hi_acc = $signed({{(c_acc_w-c_u_w){1'b0}}, w_hi_u});
    assign w_lo_acc = $signed({{(c_acc_w-c_u_w){1'b0}}, c_u_min});

    // Clamping the stored u (not just the output) prevents integrator windup.
    always_comb begin
        w_u_sat = w_sum[c_u_w-1:0];
        if (w_sum < w_lo_acc) begin
            w_u_sat = c_u_min;
        end else if (w_sum > w_hi_acc) begin
            w_u_sat = w_hi_u;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (sample_valid) w_state_next = ST_ERR;
                ST_ERR:  w_state_next = ST_MAC0;
                ST_MAC0: w_state_next = ST_MAC1;
                ST_MAC1: w_state_next = ST_MAC2;
                ST_MAC2: w_state_next = ST_SAT;
                ST_SAT:  w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // The last accumulate, clamp, u/d_n store and error-history shift all
    // happen on the edge that enters SAT, so the new d_n and d_valid are
    // presented together during the SAT cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adc    <= '0;
            r_vref   <= '0;
            r_coef_a <= '0;
            r_coef_b <= '0;
            r_coef_c <= '0;
            r_e      <= '0;
            r_e1     <= '0;
            r_e2     <= '0;
            r_acc    <= '0;
            r_u      <= '0;
            r_d_n    <= '0;
`ifdef PID_SOFT_START_EN
            r_ramp   <= c_duty_min;
`endif
        end else if (!enable) begin
            // Loop held cleared; an in-flight computation is dropped silently.
            r_e1  <= '0;
            r_e2  <= '0;
            r_u   <= c_u_min;
            r_d_n <= c_duty_min;
`ifdef PID_SOFT_START_EN
            r_ramp <= c_duty_min;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        r_adc    <= adc_code;
                        r_vref   <= vref;
                        r_coef_a <= coef_a;
                        r_coef_b <= coef_b;
                        r_coef_c <= coef_c;
                    end
                end
                ST_ERR: begin
                    r_e <= w_err;
                end
                ST_MAC0, ST_MAC1: begin
                    r_acc <= w_sum;
                end
                ST_MAC2: begin
                    r_u   <= w_u_sat;
                    r_d_n <= w_u_sat[c_u_w-1:FRAC];
                    r_e2  <= r_e1;
                    r_e1  <= r_e;
`ifdef PID_SOFT_START_EN
                    if (r_ramp < c_duty_max) begin
                        r_ramp <= r_ramp + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign d_n     = r_d_n;
    assign d_valid = (r_state == ST_SAT);
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pid_duty_compensator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_duty_compensator
// Description : Self-checking bench for pid_duty_compensator. Directed
//               scenarios followed by randomized samples, all compared
//               against an integer reference model of the PID law.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_duty_compensator;

    localparam int ADC_W    = 8;
    localparam int DUTY_W   = 6;
    localparam int COEF_W   = 10;
    localparam int FRAC     = 6;
    localparam int DUTY_MIN = 1;
    localparam int DUTY_MAX = 52;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              sample_valid;
    logic [ADC_W-1:0]  adc_code;
    logic [ADC_W-1:0]  vref;
    logic [COEF_W-1:0] coef_a;
    logic [COEF_W-1:0] coef_b;
    logic [COEF_W-1:0] coef_c;
    logic [DUTY_W-1:0] d_n;
    logic              d_valid;
    logic              busy;

    pid_duty_compensator #(
        .ADC_W    (ADC_W),
        .DUTY_W   (DUTY_W),
        .COEF_W   (COEF_W),
        .FRAC     (FRAC),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .adc_code     (adc_code),
        .vref         (vref),
        .coef_a       (coef_a),
        .coef_b       (coef_b),
        .coef_c       (coef_c),
        .d_n          (d_n),
        .d_valid      (d_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: previous output (scaled by 2^FRAC), error history
    int m_u;
    int m_e1;
    int m_e2;
    int m_ramp;
    int last_dn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int u0);
        m_u    = u0;
        m_e1   = 0;
        m_e2   = 0;
        m_ramp = DUTY_MIN;
    endtask

    // One PID update from the control law with clamp-based anti-windup.
    task automatic model_step(input int adc, input int vr, input int a,
                              input int b, input int c, output int d);
        int e;
        int s;
        int hi;
        e = vr - adc;
        s = m_u + a * e + b * m_e1 + c * m_e2;
`ifdef PID_SOFT_START_EN
        hi = m_ramp;
        if (m_ramp < DUTY_MAX) m_ramp = m_ramp + 1;
`else
        hi = DUTY_MAX;
`endif
        if (s < DUTY_MIN * 64) s = DUTY_MIN * 64;
        else if (s > hi * 64) s = hi * 64;
        m_u  = s;
        m_e2 = m_e1;
        m_e1 = e;
        d    = s / 64;
    endtask

    // Issue one sample in the current cycle T and check the whole window
    // T+1..T+6. With dup set, a second strobe (with a different code)
    // is driven in T+2 and must be ignored.
    task automatic run_sample(input int adc, input int vr, input int a,
                              input int b, input int c, input bit dup);
        int exp_d;
        adc_code     = ADC_W'(adc);
        vref         = ADC_W'(vr);
        coef_a       = COEF_W'(a);
        coef_b       = COEF_W'(b);
        coef_c       = COEF_W'(c);
        sample_valid = 1'b1;
        model_step(adc, vr, a, b, c, exp_d);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("busy_t1", 32'(busy), 32'd1);
        check("dvalid_t1", 32'(d_valid), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk); #1;
            sample_valid = dup && (k == 2);
            if (dup && k == 2) adc_code = adc_code ^ 8'h55;
            check("busy_inflight", 32'(busy), 32'd1);
            if (k == 5) begin
                check("dvalid_t5", 32'(d_valid), 32'd1);
                check("d_n", 32'(d_n), 32'(exp_d));
                last_dn = int'(d_n);
            end else begin
                check("dvalid_early", 32'(d_valid), 32'd0);
            end
        end
        sample_valid = 1'b0;
        @(posedge clk); #1;
        check("busy_t6", 32'(busy), 32'd0);
        check("dvalid_t6", 32'(d_valid), 32'd0);
        check("d_n_hold", 32'(d_n), 32'(exp_d));
    endtask

    // Hold enable low for n cycles, strobing a sample that must be ignored.
    task automatic drop_enable(input int n);
        enable       = 1'b0;
        sample_valid = 1'b1;
        adc_code     = 8'd10;
        vref         = 8'd200;
        repeat (n) begin
            @(posedge clk); #1;
            check("dis_busy", 32'(busy), 32'd0);
            check("dis_dvalid", 32'(d_valid), 32'd0);
            check("dis_dn", 32'(d_n), 32'(DUTY_MIN));
        end
        sample_valid = 1'b0;
        enable       = 1'b1;
        model_clear(DUTY_MIN * 64);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;
        rst          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        adc_code     = '0;
        vref         = '0;
        coef_a       = '0;
        coef_b       = '0;
        coef_c       = '0;
        last_dn      = 0;
        model_clear(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_dn", 32'(d_n), 32'd0);
        check("rst_dvalid", 32'(d_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Proportional-only steps from a clean state
        run_sample(96, 100, 64, 0, 0, 0);
`ifndef PID_SOFT_START_EN
        check("t1_first", 32'(last_dn), 32'd4);
`endif
        run_sample(96, 100, 64, 0, 0, 0);
`ifndef PID_SOFT_START_EN
        check("t1_second", 32'(last_dn), 32'd8);
`endif

        // Upper clamp and recovery without windup
        for (int i = 0; i < 3; i++) run_sample(100, 200, 64, 0, 0, 0);
`ifndef PID_SOFT_START_EN
        check("t2_sat_hi", 32'(last_dn), 32'd52);
`endif
        run_sample(101, 100, 64, 0, 0, 0);
`ifndef PID_SOFT_START_EN
        check("t2_unwind", 32'(last_dn), 32'd51);
`endif

        // Lower clamp
        for (int i = 0; i < 2; i++) run_sample(50, 0, 64, 0, 0, 0);
        check("t3_sat_lo", 32'(last_dn), 32'(DUTY_MIN));

        // Strobe while busy is ignored
        run_sample(90, 100, 64, -32, 16, 1);

        // Full PID with history terms
        run_sample(80, 100, 100, -60, 20, 0);
        run_sample(95, 100, 100, -60, 20, 0);

        // Asynchronous reset during MAC1
        adc_code = 8'd0; vref = 8'd255; coef_a = 10'd64;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_dn", 32'(d_n), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear(0);
        run_sample(90, 100, 64, 64, 64, 0);
        run_sample(95, 100, 64, 64, 64, 0);

        // Enable low clears the loop
        drop_enable(3);
        run_sample(90, 100, 64, 64, 64, 0);

        // Enable dropped mid-computation aborts without a d_valid
        adc_code = 8'd20; vref = 8'd200; coef_a = 10'd64;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dn", 32'(d_n), 32'(DUTY_MIN));
        enable = 1'b1;
        model_clear(DUTY_MIN * 64);
        nc = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (d_valid) nc++;
        end
        check("abort_no_dvalid", 32'(nc), 32'd0);

`ifdef PID_SOFT_START_EN
        // Soft-start ramp from DUTY_MIN up to DUTY_MAX
        drop_enable(1);
        for (int i = 0; i < 56; i++) begin
            run_sample(100, 200, 64, 0, 0, 0);
            check("ramp", 32'(last_dn), 32'((i + 1 < DUTY_MAX) ? i + 1 : DUTY_MAX));
        end
        drop_enable(1);
        run_sample(100, 200, 64, 0, 0, 0);
        check("ramp_restart", 32'(last_dn), 32'd1);
`endif

        // Randomized samples with random coefficients and idle gaps
        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            int c;
            a = int'($urandom_range(1023)) - 512;
            b = int'($urandom_range(1023)) - 512;
            c = int'($urandom_range(1023)) - 512;
            if ($urandom_range(9) == 0) drop_enable(1);
            run_sample(int'($urandom_range(255)), int'($urandom_range(255)), a, b, c,
                       bit'($urandom_range(1)));
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
